box: RTL and testbench



---
 rtl/box_if.sv | 32 +++
 rtl/box.sv | 67 ++++++
 tb/tb_box.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/box_if.sv
// Bus between the CPU-side master and the box scratch store.
// The master drives enables, address and write data; the box returns the
// registered read result and its one-cycle valid flag.
interface box_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
);
    logic              read_enable;
    logic              write_enable;
    logic [DATA_W-1:0] write_data;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] read_data;
    logic              read_active;

    modport master (
        output read_enable,
        output write_enable,
        output write_data,
        output address,
        input  read_data,
        input  read_active
    );

    modport slave (
        input  read_enable,
        input  write_enable,
        input  write_data,
        input  address,
        output read_data,
        output read_active
    );
endinterface

// File: rtl/box.sv
// box: 2**ADDR_W x DATA_W scratch/config register file with one shared
// address, synchronous write and a registered read with a one-cycle
// read_active flag.
//
// Optional build macro BOX_READ_BYPASS_EN: a read and write in the same
// cycle (necessarily the same address) return the incoming write data
// (write-first). Without it the read returns the stored word from before
// the write (read-first).
module box #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input logic   clk,
    input logic   rst,
    box_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DATA_W-1:0] read_data_q;
    logic [DATA_W-1:0] read_data_d;
    logic              read_active_q;
    logic              read_active_d;

    // Next-state: write lands in the addressed word, read samples it.
    always_comb begin
        mem_d         = mem_q;
        read_data_d   = read_data_q;
        read_active_d = bus.read_enable;

        if (bus.read_enable) begin
`ifdef BOX_READ_BYPASS_EN
            // Address is shared, so any concurrent write targets this word.
            if (bus.write_enable) begin
                read_data_d = bus.write_data;
            end else begin
                read_data_d = mem_q[bus.address];
            end
`else
            read_data_d = mem_q[bus.address];
`endif
        end

        if (bus.write_enable) begin
            mem_d[bus.address] = bus.write_data;
        end
    end

    // State registers; reset clears everything and drops any same-cycle access.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            read_data_q   <= '0;
            read_active_q <= 1'b0;
        end else begin
            mem_q         <= mem_d;
            read_data_q   <= read_data_d;
            read_active_q <= read_active_d;
        end
    end

    assign bus.read_data   = read_data_q;
    assign bus.read_active = read_active_q;
endmodule

// File: tb/tb_box.sv
// Self-checking bench for box: a reference model pushes the expected
// {read_active, read_data} for every driven cycle and a negedge checker
// pops and compares it against the DUT. Directed points add fixed values.
module tb_box;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;

    logic clk = 1'b0;
    logic rst;

    box_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    box #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              act;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t              sb [$];
    logic [DATA_W-1:0] ref_mem [4];
    logic [DATA_W-1:0] ref_rd;
    int                n_checks = 0;
    int                n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model update for one rising edge, using the inputs in force at that edge.
    task automatic model_edge(input logic r, input logic re, input logic we,
                              input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        exp_t e;
        if (r) begin
            for (int i = 0; i < 4; i++) ref_mem[i] = '0;
            ref_rd = '0;
            e = '{act: 1'b0, data: '0};
        end else begin
            if (re) begin
`ifdef BOX_READ_BYPASS_EN
                ref_rd = we ? d : ref_mem[a];
`else
                ref_rd = ref_mem[a];
`endif
            end
            if (we) ref_mem[a] = d;
            e = '{act: re, data: ref_rd};
        end
        sb.push_back(e);
    endtask

    task automatic cyc(input logic r, input logic re, input logic we,
                       input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        rst              = r;
        bus.read_enable  = re;
        bus.write_enable = we;
        bus.address      = a;
        bus.write_data   = d;
        @(posedge clk);
        model_edge(r, re, we, a, d);
    endtask

    // Scoreboard checker: one expectation per edge, compared mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("sb_read_active", 32'(bus.read_active), 32'(e.act));
            chk("sb_read_data", 32'(bus.read_data), 32'(e.data));
        end
    end

    initial begin
        rst              = 1'b1;
        bus.read_enable  = 1'b0;
        bus.write_enable = 1'b0;
        bus.address      = '0;
        bus.write_data   = '0;

        // Reset for two cycles, then read every word back as zero.
        cyc(1, 0, 0, 0, 8'h00);
        cyc(1, 0, 0, 0, 8'h00);
        for (int a = 0; a < 4; a++) begin
            cyc(0, 1, 0, 2'(a), 8'h00);
            #1;
            chk("reset_word", 32'(bus.read_data), 32'h00);
            chk("reset_word_active", 32'(bus.read_active), 32'h1);
        end

        // Write / readback.
        cyc(0, 0, 1, 0, 8'hAA);
        cyc(0, 0, 1, 1, 8'h55);
        cyc(0, 1, 0, 0, 8'h00);
        #1 chk("readback_0", 32'(bus.read_data), 32'hAA);
        cyc(0, 1, 0, 1, 8'h00);
        #1 chk("readback_1", 32'(bus.read_data), 32'h55);

        // Hold: data stays, flag drops.
        cyc(0, 1, 0, 1, 8'h00);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 8'h00);
        #1;
        chk("hold_data", 32'(bus.read_data), 32'h55);
        chk("hold_active", 32'(bus.read_active), 32'h0);

        // Collision on word 2.
        cyc(0, 0, 1, 2, 8'h0F);
        cyc(0, 1, 1, 2, 8'hF0);
        #1;
`ifdef BOX_READ_BYPASS_EN
        chk("collision", 32'(bus.read_data), 32'hF0);
`else
        chk("collision", 32'(bus.read_data), 32'h0F);
`endif
        cyc(0, 1, 0, 2, 8'h00);
        #1 chk("collision_after", 32'(bus.read_data), 32'hF0);

        // Reset priority over same-cycle read and write.
        cyc(0, 0, 1, 3, 8'h77);
        cyc(1, 1, 1, 3, 8'h33);
        #1;
        chk("rst_prio_active", 32'(bus.read_active), 32'h0);
        chk("rst_prio_data", 32'(bus.read_data), 32'h00);
        cyc(0, 1, 0, 3, 8'h00);
        #1 chk("rst_prio_word3", 32'(bus.read_data), 32'h00);

        // Sub-cycle write pulse must not land.
        cyc(0, 0, 1, 0, 8'h12);
        @(negedge clk);
        rst              = 1'b0;
        bus.read_enable  = 1'b0;
        bus.address      = 2'd0;
        bus.write_data   = 8'hAA;
        #2 bus.write_enable = 1'b1;
        #2 bus.write_enable = 1'b0;
        @(posedge clk);
        model_edge(0, 0, 0, 0, 8'hAA);
        cyc(0, 1, 0, 0, 8'h00);
        #1 chk("pulse_no_write", 32'(bus.read_data), 32'h12);

        // Back-to-back reads, one result per cycle.
        for (int a = 0; a < 4; a++) cyc(0, 1, 0, 2'(a), 8'h00);

        // Random traffic through the scoreboard.
        for (int i = 0; i < 60; i++) begin
            cyc(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
        end

        cyc(0, 0, 0, 0, 8'h00);
        @(negedge clk);
        @(negedge clk);
        #1 chk("sb_drained", 32'(sb.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
